uart_rx_oversampled: RTL and testbench

// - Oversampling UART receiver (8N1): the receive end of the link whose transmitter sends one byte per button press.
// - Sits between board pin rx_uart and the display/control logic.
// - Synchronises the line, validates the start bit and majority-votes each bit at mid-bit.
// - Delivers each byte with a one-cycle valid strobe and flags framing errors.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_oversampled.sv | 141 ++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM encoding,
// frame width and the baud divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_tick_div(input longint clk_hz, input longint baud,
                                       input longint ovs);
    return int'((clk_hz + (baud * ovs) / 2) / (baud * ovs));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running mod-TICK_DIV counter that can be
// restarted synchronously so ticks line up with a detected start edge.
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == CNT_MAX) && !restart;
    if (restart || cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: synchronises rx_uart, validates the start bit and
// majority-votes three oversamples per bit; reports good bytes and framing errors.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int INPUT_CLK  = 50000000,
  parameter int BAUD_RATE  = 230400,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int TICK_DIV = calc_tick_div(longint'(INPUT_CLK), longint'(BAUD_RATE),
                                          longint'(OVERSAMPLE));
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  // Votes sit on the ticks ending eighths 2..4, so the decision lands on mid-bit.
  localparam logic [SW-1:0] VOTE_0 = SW'(OVERSAMPLE / 2 - 3);
  localparam logic [SW-1:0] VOTE_1 = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] VOTE_2 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           votes_q, votes_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_s, tick, restart, majority, vote_end, bit_end;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  assign rx_s     = sync_q[1];
  assign majority = (votes_q[0] & votes_q[1]) | (rx_s & (votes_q[0] | votes_q[1]));
  assign vote_end = tick && (s_q == VOTE_2);
  assign bit_end  = tick && (s_q == S_LAST);

  always_comb begin
    sync_d      = {sync_q[0], rx_uart};
    state_d     = state_q;
    s_d         = s_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    votes_d     = votes_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;

    if (state_q != IDLE && tick) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      if (s_q == VOTE_0) votes_d[0] = rx_s;
      if (s_q == VOTE_1) votes_d[1] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
          restart = 1'b1;
        end
      end
      START: begin
        if (vote_end && majority) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (vote_end) shift_d = {majority, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (vote_end) begin
          if (majority) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      s_q         <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      votes_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      s_q         <= s_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      votes_q     <= votes_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: the line driver queues the expected
// outcome of each frame, a monitor pops and compares on every rx_valid/frame_err.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int CLK_NS  = 20;
  localparam int BIT_NOM = 217;  // nearest whole clk to 217.01

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_uart = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_oversampled dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_uart   (rx_uart),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         start_cyc;
    logic       chk_lat;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one 8N1 frame; spike_mask marks frame positions (0=start) that get a
  // noise pulse shorter than one oversample tick near the bit's vote window.
  task automatic send(input logic [7:0] b, input int bit_clk, input logic stop_val,
                      input logic [9:0] spike_mask, input logic chk_lat);
    exp_t e;
    logic v;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stop_val : b[i-1];
      rx_uart = v;
      if (i == 0) begin
        e.is_err    = !stop_val;
        e.data      = stop_val ? b : last_good;
        e.start_cyc = cyc;
        e.chk_lat   = chk_lat;
        exp_q.push_back(e);
        if (stop_val) last_good = b;
      end
      if (spike_mask[i]) begin
        #(64 * CLK_NS);
        rx_uart = ~v;
        #(24 * CLK_NS);
        rx_uart = v;
        #((bit_clk - 88) * CLK_NS);
      end else begin
        #(bit_clk * CLK_NS);
      end
    end
  endtask

  task automatic idle_clks(input int n);
    rx_uart = 1'b1;
    #(n * CLK_NS);
  endtask

  initial begin : monitor
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: rx_valid=%b frame_err=%b rx_byte=0x%h, expected no output",
                   rx_valid, frame_err, rx_byte);
        end else begin
          e = exp_q.pop_front();
          check("frame_err_pulse", 32'(frame_err), 32'(e.is_err));
          check("rx_valid_pulse", 32'(rx_valid), 32'(!e.is_err));
          check("rx_byte", 32'(rx_byte), 32'(e.data));
          if (e.chk_lat) begin
            lat = cyc - e.start_cyc;
            n_vec++;
            if (lat < 2050 || lat > 2060) begin
              n_err++;
              $display("FAIL latency: got %0d clk, expected 2050..2060", lat);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_byte", 32'(rx_byte), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #3;

    // Two nominal-rate frames with latency measurement.
    send(8'h55, BIT_NOM, 1'b1, 10'h000, 1'b1);
    idle_clks(2 * BIT_NOM);
    send(8'hA3, BIT_NOM, 1'b1, 10'h000, 1'b1);
    idle_clks(2 * BIT_NOM);

    // 40-clk low glitch must be rejected as a false start.
    rx_uart = 1'b0;
    #(10 * CLK_NS);
    check("glitch_busy_high", 32'(busy), 32'h1);
    #(30 * CLK_NS);
    rx_uart = 1'b1;
    #(200 * CLK_NS);
    check("glitch_busy_idle", 32'(busy), 32'h0);
    send(8'h3C, BIT_NOM, 1'b1, 10'h000, 1'b0);
    idle_clks(2 * BIT_NOM);

    // Stop bit low, line held low for two more bits.
    send(8'hF0, BIT_NOM, 1'b0, 10'h000, 1'b0);
    #(2 * BIT_NOM * CLK_NS);
    check("wait_hi_busy", 32'(busy), 32'h1);
    rx_uart = 1'b1;
    #(10 * CLK_NS);
    check("wait_hi_release_busy", 32'(busy), 32'h0);
    check("rx_byte_kept_after_ferr", 32'(rx_byte), 32'h3C);
    idle_clks(2 * BIT_NOM);

    // Back-to-back frames at nominal, fast and slow bit periods.
    send(8'h00, BIT_NOM, 1'b1, 10'h000, 1'b0);
    send(8'hFF, BIT_NOM, 1'b1, 10'h000, 1'b0);
    send(8'h81, BIT_NOM, 1'b1, 10'h000, 1'b0);
    idle_clks(2 * BIT_NOM);
    send(8'h00, 210, 1'b1, 10'h000, 1'b0);
    send(8'hFF, 210, 1'b1, 10'h000, 1'b0);
    send(8'h81, 210, 1'b1, 10'h000, 1'b0);
    idle_clks(2 * BIT_NOM);
    send(8'h00, 224, 1'b1, 10'h000, 1'b0);
    send(8'hFF, 224, 1'b1, 10'h000, 1'b0);
    send(8'h81, 224, 1'b1, 10'h000, 1'b0);
    idle_clks(2 * BIT_NOM);

    // Reset in the middle of data bit 4 of 0x96 (frame position 5).
    rx_uart = 1'b0;
    #(BIT_NOM * CLK_NS);
    for (int i = 0; i < 4; i++) begin
      rx_uart = (8'h96 >> i) & 8'h01 ? 1'b1 : 1'b0;
      #(BIT_NOM * CLK_NS);
    end
    rx_uart = 1'b1;
    #((BIT_NOM / 2) * CLK_NS);
    reset_n = 1'b0;
    #1;
    check("midreset_rx_byte", 32'(rx_byte), 32'h00);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    #(3 * BIT_NOM * CLK_NS);
    check("after_reset_rx_byte", 32'(rx_byte), 32'h00);
    check("after_reset_busy", 32'(busy), 32'h0);
    send(8'h69, BIT_NOM, 1'b1, 10'h000, 1'b0);
    idle_clks(2 * BIT_NOM);

    // 0xAA with one vote sample inverted in data bit 1 (high) and bit 6 (low).
    send(8'hAA, BIT_NOM, 1'b1, 10'h084, 1'b0);
    idle_clks(100);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_output: got none, expected %s with rx_byte=0x%h",
               e.is_err ? "frame_err" : "rx_valid", e.data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
